// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and helpers for the dmem_sync_clr data memory
package dmem_pkg;

  // Controller states: normal access service, or the clear engine owning the array
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // Read-during-write behaviour of the array primitive
  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  // Number of byte lanes in a data word
  function automatic int lane_count(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - single-port synchronous RAM with byte-lane write enables
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DW       = 8,
  parameter int AW       = 8,
  parameter int RDW_MODE = RDW_OLD
) (
  input  logic            clk,
  input  logic [DW/8-1:0] we,
  input  logic            re,
  input  logic [AW-1:0]   addr,
  input  logic [DW-1:0]   wdata,
  output logic [DW-1:0]   rdata
);

  localparam int NB = lane_count(DW);

  logic [DW-1:0] mem [2**AW];

  // Byte-lane writes; lanes with a clear enable keep their old contents
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (we[i]) begin
        mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  // Registered read port; it only updates on a read, so the last result is held
  always_ff @(posedge clk) begin
    if (re) begin
      for (int i = 0; i < NB; i++) begin
        if (RDW_MODE == RDW_NEW && we[i]) begin
          rdata[i*8 +: 8] <= wdata[i*8 +: 8];
        end else begin
          rdata[i*8 +: 8] <= mem[addr][i*8 +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/dmem_sync_clr.sv
// rtl/dmem_sync_clr.sv - parametrised data memory with access handshake and clear engine
module dmem_sync_clr
  import dmem_pkg::*;
#(
  parameter int            DW             = 8,
  parameter int            AW             = 8,
  parameter logic [DW-1:0] INIT_VAL       = '0,
  parameter bit            CLEAR_ON_RESET = 1'b1,
  parameter int            RDW_MODE       = RDW_OLD
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req,
  input  logic            we,
  input  logic [DW/8-1:0] be,
  input  logic [AW-1:0]   addr,
  input  logic [DW-1:0]   wdata,
  output logic            ready,
  output logic [DW-1:0]   rdata,
  output logic            rvalid,
  input  logic            clr_req,
  output logic            busy,
  output logic            clr_done
);

  if (DW % 8 != 0) begin : g_dw_check
    $error("dmem_sync_clr: DW must be a multiple of 8");
  end

  localparam int            NB       = lane_count(DW);
  localparam logic [AW-1:0] CNT_LAST = '1;

  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            rvalid_q;
  logic [DW-1:0]   hold_q;

  logic            acc_rd, acc_wr;
  logic [NB-1:0]   arr_we;
  logic            arr_re;
  logic [AW-1:0]   arr_addr;
  logic [DW-1:0]   arr_wdata;
  logic [DW-1:0]   arr_rdata;

  assign ready    = (state_q == IDLE);
  assign busy     = (state_q == CLEAR);
  assign clr_done = (state_q == CLEAR) && (cnt_q == CNT_LAST);

  assign acc_rd = req && ready && !we;
  assign acc_wr = req && ready && we;

  // State, clear counter and read-valid registers; reset aborts any clear in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= CLEAR_ON_RESET ? CLEAR : IDLE;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= acc_rd;
    end
  end

  // Next-state logic: clr_req is only honoured from IDLE, so it cannot restart a clear
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (clr_req) begin
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Array port mux: the clear engine owns the port while busy, else the accepted access
  always_comb begin
    arr_we    = '0;
    arr_re    = 1'b0;
    arr_addr  = addr;
    arr_wdata = wdata;
    if (state_q == CLEAR) begin
      arr_we    = '1;
      arr_addr  = cnt_q;
      arr_wdata = INIT_VAL;
    end else if (acc_wr) begin
      arr_we = be;
    end else if (acc_rd) begin
      arr_re = 1'b1;
    end
  end

  // Resettable copy of the last read result so rdata is defined from reset onward
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else if (rvalid_q) begin
      hold_q <= arr_rdata;
    end
  end

  assign rvalid = rvalid_q;
  assign rdata  = rvalid_q ? arr_rdata : hold_q;

  dmem_array #(
    .DW       (DW),
    .AW       (AW),
    .RDW_MODE (RDW_MODE)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .re    (arr_re),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

endmodule

// File: tb/tb_dmem_sync_clr.sv
// tb/tb_dmem_sync_clr.sv - self-checking bench for dmem_sync_clr
module tb_dmem_sync_clr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Instance A: 32-bit x 256, clears to zero after reset
  logic        a_rst_n, a_req, a_we, a_clr;
  logic [3:0]  a_be;
  logic [7:0]  a_addr;
  logic [31:0] a_wdata, a_rdata;
  logic        a_ready, a_rvalid, a_busy, a_done;

  // Instance B: 8-bit x 16, no clear on reset, INIT_VAL=0xA5, write-first array
  logic        b_rst_n, b_req, b_we, b_clr;
  logic [0:0]  b_be;
  logic [3:0]  b_addr;
  logic [7:0]  b_wdata, b_rdata;
  logic        b_ready, b_rvalid, b_busy, b_done;

  dmem_sync_clr #(.DW(32), .AW(8), .INIT_VAL(32'h0), .CLEAR_ON_RESET(1'b1), .RDW_MODE(0)) dut_a (
    .clk(clk), .rst_n(a_rst_n), .req(a_req), .we(a_we), .be(a_be), .addr(a_addr),
    .wdata(a_wdata), .ready(a_ready), .rdata(a_rdata), .rvalid(a_rvalid),
    .clr_req(a_clr), .busy(a_busy), .clr_done(a_done));

  dmem_sync_clr #(.DW(8), .AW(4), .INIT_VAL(8'hA5), .CLEAR_ON_RESET(1'b0), .RDW_MODE(1)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .req(b_req), .we(b_we), .be(b_be), .addr(b_addr),
    .wdata(b_wdata), .ready(b_ready), .rdata(b_rdata), .rvalid(b_rvalid),
    .clr_req(b_clr), .busy(b_busy), .clr_done(b_done));

  // Reference model for A: word array, remaining clear cycles, expected read outputs
  logic [31:0] m_mem [256];
  int          m_busy;
  logic        m_rvalid;
  logic [31:0] m_rdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_a();
    chk("a_ready",    {31'b0, a_ready},  {31'b0, m_busy == 0});
    chk("a_busy",     {31'b0, a_busy},   {31'b0, m_busy != 0});
    chk("a_clr_done", {31'b0, a_done},   {31'b0, m_busy == 1});
    chk("a_rvalid",   {31'b0, a_rvalid}, {31'b0, m_rvalid});
    chk("a_rdata",    a_rdata,           m_rdata);
  endtask

  // One clock on A: drive at negedge, advance the model, check at the next negedge
  task automatic cyc_a(input logic req, input logic we, input logic [3:0] be,
                       input logic [7:0] addr, input logic [31:0] wd, input logic clr);
    logic acc;
    a_req = req; a_we = we; a_be = be; a_addr = addr; a_wdata = wd; a_clr = clr;
    acc = req && (m_busy == 0);
    m_rvalid = acc && !we;
    if (acc && !we) m_rdata = m_mem[addr];
    if (acc && we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) m_mem[addr][i*8 +: 8] = wd[i*8 +: 8];
      end
    end
    if (m_busy > 0) begin
      m_busy--;
    end else if (clr) begin
      m_busy = 256;
      foreach (m_mem[k]) m_mem[k] = 32'h0;
    end
    @(posedge clk);
    @(negedge clk);
    check_a();
  endtask

  task automatic idle_a(input int n);
    for (int i = 0; i < n; i++) cyc_a(1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0);
  endtask

  // Assert A's reset at a negedge, check the asynchronous values, release after n cycles
  task automatic reset_a(input int n);
    a_rst_n = 1'b0;
    a_req = 1'b0; a_we = 1'b0; a_clr = 1'b0;
    m_busy = 256; m_rvalid = 1'b0; m_rdata = 32'h0;
    foreach (m_mem[k]) m_mem[k] = 32'h0;
    #1;
    check_a();
    repeat (n) @(negedge clk);
    check_a();
    a_rst_n = 1'b1;
  endtask

  typedef struct {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [7:0]  addr;
    logic [31:0] wd;
    logic        exp_rv;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [11];

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 4'h0, 8'h00, 32'h0,         1'b1, 32'h0000_0000};
    vecs[1]  = '{1'b1, 1'b0, 4'h0, 8'h7F, 32'h0,         1'b1, 32'h0000_0000};
    vecs[2]  = '{1'b1, 1'b0, 4'h0, 8'hFF, 32'h0,         1'b1, 32'h0000_0000};
    vecs[3]  = '{1'b1, 1'b1, 4'hF, 8'h05, 32'hAABBCCDD,  1'b0, 32'h0};
    vecs[4]  = '{1'b1, 1'b1, 4'h5, 8'h05, 32'h11223344,  1'b0, 32'h0};
    vecs[5]  = '{1'b1, 1'b0, 4'h0, 8'h05, 32'h0,         1'b1, 32'hAA22CC44};
    vecs[6]  = '{1'b1, 1'b1, 4'hF, 8'h09, 32'h0000_0033, 1'b0, 32'h0};
    vecs[7]  = '{1'b1, 1'b0, 4'h0, 8'h09, 32'h0,         1'b1, 32'h0000_0033};
    vecs[8]  = '{1'b0, 1'b0, 4'h0, 8'h09, 32'h0,         1'b0, 32'h0};
    vecs[9]  = '{1'b1, 1'b1, 4'h0, 8'h09, 32'hFFFF_FFFF, 1'b0, 32'h0};
    vecs[10] = '{1'b1, 1'b0, 4'h0, 8'h09, 32'h0,         1'b1, 32'h0000_0033};

    a_rst_n = 1'b0; a_req = 1'b0; a_we = 1'b0; a_be = 4'h0; a_addr = 8'h0; a_wdata = 32'h0; a_clr = 1'b0;
    b_rst_n = 1'b0; b_req = 1'b0; b_we = 1'b0; b_be = 1'b0; b_addr = 4'h0; b_wdata = 8'h0; b_clr = 1'b0;

    @(negedge clk);
    reset_a(2);
    b_rst_n = 1'b1;

    // Power-on clear; a read and a write while busy must be ignored
    idle_a(10);
    cyc_a(1'b1, 1'b0, 4'h0, 8'h10, 32'h0, 1'b0);
    cyc_a(1'b1, 1'b1, 4'hF, 8'h10, 32'hFFFF_FFFF, 1'b0);
    idle_a(244);

    // Directed vector table
    for (int i = 0; i < 11; i++) begin
      cyc_a(vecs[i].req, vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wd, 1'b0);
      chk($sformatf("vec%0d_rvalid", i), {31'b0, a_rvalid}, {31'b0, vecs[i].exp_rv});
      if (vecs[i].exp_rv) chk($sformatf("vec%0d_rdata", i), a_rdata, vecs[i].exp_rd);
    end
    cyc_a(1'b1, 1'b0, 4'h0, 8'h10, 32'h0, 1'b0);
    chk("busy_write_ignored", a_rdata, 32'h0);

    // Read coinciding with clr_req returns pre-clear data, then the clear follows
    cyc_a(1'b1, 1'b1, 4'hF, 8'h03, 32'h0000_005A, 1'b0);
    cyc_a(1'b1, 1'b0, 4'h0, 8'h03, 32'h0, 1'b1);
    chk("pre_clear_rdata", a_rdata, 32'h0000_005A);
    chk("pre_clear_busy", {31'b0, a_busy}, 32'h1);
    idle_a(256);
    cyc_a(1'b1, 1'b0, 4'h0, 8'h03, 32'h0, 1'b0);
    chk("post_clear_rdata", a_rdata, 32'h0);

    // Reset at clear cycle 100 restarts a full clear; a second clr_req does not extend it
    cyc_a(1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b1);
    idle_a(99);
    reset_a(2);
    idle_a(50);
    cyc_a(1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b1);
    idle_a(210);

    // Randomised traffic with occasional clears
    for (int i = 0; i < 3000; i++) begin
      cyc_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom),
            8'($urandom), $urandom, ($urandom_range(0, 399) == 0));
    end
    idle_a(260);

    // Instance B: ready immediately after reset, manual clear to INIT_VAL
    chk("b_ready_after_reset", {31'b0, b_ready}, 32'h1);
    chk("b_busy_after_reset", {31'b0, b_busy}, 32'h0);
    chk("b_rdata_reset", {24'b0, b_rdata}, 32'h0);
    b_req = 1'b1; b_we = 1'b1; b_be = 1'b1; b_addr = 4'h2; b_wdata = 8'h3C;
    @(posedge clk); @(negedge clk);
    b_we = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("b_rvalid", {31'b0, b_rvalid}, 32'h1);
    chk("b_rdata", {24'b0, b_rdata}, 32'h3C);
    b_req = 1'b0; b_clr = 1'b1;
    @(posedge clk); @(negedge clk);
    b_clr = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("b_busy_c%0d", i), {31'b0, b_busy}, 32'h1);
      chk($sformatf("b_done_c%0d", i), {31'b0, b_done}, {31'b0, i == 15});
      @(posedge clk); @(negedge clk);
    end
    chk("b_ready_after_clear", {31'b0, b_ready}, 32'h1);
    b_req = 1'b1; b_we = 1'b0; b_addr = 4'h2;
    @(posedge clk); @(negedge clk);
    b_req = 1'b0;
    chk("b_clear_rvalid", {31'b0, b_rvalid}, 32'h1);
    chk("b_clear_rdata", {24'b0, b_rdata}, 32'hA5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_sync_clr.md
Name: dmem_sync_clr

Overview:
Parametrised single-port synchronous data memory, the next-generation replacement for the current 256x8 data memory.
- Adds width/depth parameters, byte-lane write enables and a selectable read-during-write mode.
- Adds a valid/ready access handshake and a built-in clear engine that initialises every word after reset or on request.
- Sits between the core's load/store stage and the data address space; the core must hold requests until ready is high.

Parameters:
DW, 8, data word width in bits; must be a multiple of 8.
AW, 8, address width; depth = 2**AW words.
INIT_VAL, 0, DW-bit value written to every word by the clear engine.
CLEAR_ON_RESET, 1, 1: clear engine runs automatically after reset release; 0: reset enters IDLE.
RDW_MODE, 0, 0: a same-address read+write returns old data; 1: it returns new data (write-first, per byte lane).

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req  in  1  access request, qualified by ready
we  in  1  1 = write, 0 = read
be  in  DW/8  byte-lane write enables; ignored on reads
addr  in  AW  word address
wdata  in  DW  write data
ready  out  1  block accepts an access this cycle
rdata  out  DW  read data, valid when rvalid is high
rvalid  out  1  one-cycle pulse, one cycle after an accepted read
clr_req  in  1  start a full clear (pulse)
busy  out  1  clear engine active
clr_done  out  1  one-cycle pulse on the cycle the last word is written

Behaviour:
- Reset values (asynchronous, while rst_n=0):
  - rdata=0, rvalid=0, clr_done=0, clear counter=0.
  - State=CLEAR if CLEAR_ON_RESET=1, else IDLE.
  - busy and ready are decoded from state.
  - Array contents are not reset.
- States: IDLE, CLEAR.
  - ready = (state==IDLE); busy = (state==CLEAR).
- Accepted access: req && ready on a rising edge.
  - Write: memory[addr] byte lane i <= wdata lane i wherever be[i]=1. be=0 is a legal no-op.
  - Read: rdata <= memory[addr] and rvalid=1 on the next cycle (latency 1).
  - rdata holds its last value when rvalid=0.
  - Back-to-back accesses are allowed every cycle.
- req while ready=0: ignored, no side effects; the requester must retry.
- Clear engine, in CLEAR:
  - Each cycle writes INIT_VAL to memory[cnt] and increments cnt.
  - At cnt == 2**AW-1: that write occurs, clr_done pulses, cnt wraps to 0, next state is IDLE.
  - A clear takes exactly 2**AW cycles.
- IDLE -> CLEAR on clr_req=1.
  - An access accepted in that same cycle completes normally (a read returns pre-clear data).
  - Clearing starts the following cycle.
- clr_req while busy: ignored; no restart, no extension.
- Reset asserted mid-clear: aborts immediately. After release, behaviour follows CLEAR_ON_RESET; the clear restarts from address 0.
- Read-during-write: the single port cannot issue a read and a write in the same cycle. RDW_MODE governs only the internal array primitive used by the clear path and must match in the sub-module.
- Address wrap: addr is exactly AW bits; there is no out-of-range condition.
- Elaboration error if DW%8 != 0.

Decomposition:
- Package dmem_pkg:
  - State enum (IDLE, CLEAR).
  - RDW_OLD/RDW_NEW constants.
  - Helper function for the byte-lane count (DW/8).
- Sub-module dmem_array: plain synchronous RAM with per-byte write enables, one registered read port, no reset, parameters DW/AW/RDW_MODE.
- The top level contains the FSM, clear counter, write mux (clear vs access) and rvalid register.

Test Plan:
- Reset release, CLEAR_ON_RESET=1, AW=8 -> busy=1 and ready=0 for 256 cycles; clr_done pulses on cycle 256; then reads of addr 0x00, 0x7F and 0xFF return 0x00 with rvalid one cycle later.
- DW=32, write addr 5 wdata 0xAABBCCDD be=4'b1111, then write addr 5 wdata 0x11223344 be=4'b0101 -> read addr 5 returns 0xAA22CC44.
- Write addr 3=0x5A, then clr_req pulse in the same cycle as a read of addr 3 -> rdata=0x5A with rvalid next cycle; busy rises; after clr_done, read addr 3 returns INIT_VAL.
- Assert rst_n=0 at clear cycle 100, release -> clear restarts at address 0 and takes a full 256 cycles; a second clr_req pulse during busy does not extend it.
- req with we=0 while busy -> no rvalid, no array change; CLEAR_ON_RESET=0 -> ready=1 the first cycle after reset.
- Back-to-back: write addr 9=0x33, read addr 9 next cycle -> rdata=0x33, rvalid exactly one pulse.
